// File: rtl/aux_pkg.sv
// Purpose: shared types and helpers for the aux utility layer (timer FSM state, index width helper).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aux_pkg;

   // Shared one-shot timer FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tmr_state_e;

   // Number of bits needed to hold an index in 0..n-1 (never less than 1).
   function automatic int log2ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/aux_rr_pick.sv
// Purpose: combinational round-robin selector; search starts just after 'last' and wraps.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on 'valid'.
// Ports: req (request vector), last (previous owner index) -> valid, sel (one-hot), idx (binary).
module aux_rr_pick
   import aux_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int IdxW   = log2ceil(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   last,
   output logic              valid,
   output logic [NumReq-1:0] sel,
   output logic [IdxW-1:0]   idx
);

   logic [IdxW-1:0] cand;

   // Walk candidates last+1, last+2, ... last+NumReq (mod NumReq); first hit wins.
   always_comb begin
      valid = 1'b0;
      sel   = '0;
      idx   = '0;
      cand  = '0;
      for (int k = 1; k <= NumReq; k++) begin
         cand = IdxW'((int'(last) + k) % NumReq);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            sel[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/aux_timer_arbiter.sv
// Purpose: one shared down-counter granted round-robin to NumReq requesters; one-cycle done pulse.
// Latency: req at edge T -> gnt at T+1 for D cycles, done at T+D+1, idle at T+D+2 (D=0 acts as 1).
// Backpressure: level req held until done; losers simply wait. Optional macro AUX_TIMER_ABORT_EN
//   lets the owner cancel by dropping req mid-run (no done issued).
// Ports: clk, rst (sync, active-high), req, dly (flat, CntBit per requester) -> gnt, done, busy, remain.
module aux_timer_arbiter
   import aux_pkg::*;
#(
   parameter int NumReq = 4,
   parameter int CntBit = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NumReq-1:0]        req,
   input  logic [NumReq*CntBit-1:0] dly,
   output logic [NumReq-1:0]        gnt,
   output logic [NumReq-1:0]        done,
   output logic                     busy,
   output logic [CntBit-1:0]        remain
);

   localparam int                IdxW    = log2ceil(NumReq);
   localparam logic [CntBit-1:0] CntOne  = CntBit'(1);
   localparam logic [IdxW-1:0]   LastRst = IdxW'(NumReq - 1);

   tmr_state_e        state_q, state_d;
   logic [IdxW-1:0]   own_q,   own_d;
   logic [IdxW-1:0]   last_q,  last_d;
   logic [CntBit-1:0] cnt_q,   cnt_d;
   logic [NumReq-1:0] gnt_q,   gnt_d;
   logic [NumReq-1:0] done_q,  done_d;
   logic              busy_q,  busy_d;

   logic              pick_vld;
   logic [NumReq-1:0] pick_sel;
   logic [IdxW-1:0]   pick_idx;
   logic [CntBit-1:0] pick_dly;

   aux_rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_vld),
      .sel   (pick_sel),
      .idx   (pick_idx)
   );

   // Delay is only looked at in the grant cycle; later changes on dly are ignored.
   assign pick_dly = dly[pick_idx*CntBit +: CntBit];

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               own_d   = pick_idx;
               // Zero delay is stretched to one cycle so the counter never starts at 0.
               cnt_d   = (pick_dly == '0) ? CntOne : pick_dly;
               gnt_d   = pick_sel;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef AUX_TIMER_ABORT_EN
            // Owner withdrawal beats completion, even on the last count.
            if (!req[own_q]) begin
               last_d  = own_q;
               cnt_d   = '0;
               gnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else
`endif
            if (cnt_q == CntOne) begin
               cnt_d         = '0;
               gnt_d         = '0;
               done_d[own_q] = 1'b1;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         ST_DONE: begin
            // Pointer moves only after service so the next search starts past this owner.
            last_d  = own_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         own_q   <= '0;
         last_q  <= LastRst;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign remain = cnt_q;

endmodule

// File: tb/tb_aux_timer_arbiter.sv
// Purpose: self-checking bench for aux_timer_arbiter: directed scenarios plus randomized requesters.
// Latency: n/a (testbench).
// Backpressure: requester agents follow the hold-until-done protocol.
module tb_aux_timer_arbiter;

   localparam int NREQ = 4;
   localparam int CB   = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*CB-1:0]   dly = '0;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic                 busy;
   logic [CB-1:0]        remain;

   aux_timer_arbiter #(.NumReq(NREQ), .CntBit(CB)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .dly    (dly),
      .gnt    (gnt),
      .done   (done),
      .busy   (busy),
      .remain (remain)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference: who holds the timer (-1 none), cycles of grant left, who is in the done slot, last served.
   int m_own  = -1;
   int m_rem  = 0;
   int m_dn   = -1;
   int m_last = NREQ - 1;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_own = -1; m_rem = 0; m_dn = -1; m_last = NREQ - 1;
      end else if (m_dn >= 0) begin
         m_last = m_dn;
         m_dn   = -1;
      end else if (m_own >= 0) begin
`ifdef AUX_TIMER_ABORT_EN
         if (!req[m_own]) begin
            m_last = m_own; m_own = -1; m_rem = 0;
         end else
`endif
         if (m_rem == 1) begin
            m_dn = m_own; m_own = -1; m_rem = 0;
         end else begin
            m_rem = m_rem - 1;
         end
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req[i]) begin
               m_own = i;
               m_rem = int'(dly[i*CB +: CB]);
               if (m_rem == 0) m_rem = 1;
               break;
            end
         end
      end
   endtask

   function automatic logic [31:0] onehot(input int i);
      return (i >= 0) ? (32'd1 << i) : 32'd0;
   endfunction

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("gnt",    gnt,    onehot(m_own));
         chk("done",   done,   onehot(m_dn));
         chk("busy",   busy,   (m_own >= 0 || m_dn >= 0) ? 32'd1 : 32'd0);
         chk("remain", remain, m_rem);
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic setd(input int i, input int v);
      dly[i*CB +: CB] = CB'(v);
   endtask

   initial begin
      int gq[$];
      int gt[$];
      int rr_cd[NREQ];
      int gap[NREQ];
      logic [NREQ-1:0] pg;

      // Reset state
      rst = 1'b1;
      cyc();
      cmp_en = 1'b1;
      chk("rst_gnt", gnt, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_remain", remain, 32'd0);
      cyc();
      rst = 1'b0;

      // Single request, D=5 on requester 2
      setd(2, 5);
      req = 4'b0100;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("single_gnt", gnt, (k <= 5) ? 32'h4 : 32'h0);
         chk("single_done", done, (k == 6) ? 32'h4 : 32'h0);
         chk("single_busy", busy, (k <= 6) ? 32'd1 : 32'd0);
         chk("single_remain", remain, (k <= 5) ? 32'(6 - k) : 32'd0);
         if (k == 6) req = '0;
      end

      // Zero delay on requester 0
      setd(0, 0);
      req = 4'b0001;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk("zero_gnt", gnt, (k == 1) ? 32'h1 : 32'h0);
         chk("zero_done", done, (k == 2) ? 32'h1 : 32'h0);
         if (k == 2) req = '0;
      end

      // Owner drops req mid-run, requester 3 waiting
      setd(1, 10);
      req = 4'b0010;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 4) chk("drop_remain", remain, 32'd7);
`ifdef AUX_TIMER_ABORT_EN
         if (k == 5) chk("abort_gnt", gnt, 32'h0);
         if (k == 5) chk("abort_busy", busy, 32'd0);
         if (k == 6) chk("abort_next_gnt", gnt, 32'h8);
`else
         if (k == 10) chk("noabort_gnt", gnt, 32'h2);
         if (k == 11) chk("noabort_done", done, 32'h2);
         if (k == 13) chk("noabort_next_gnt", gnt, 32'h8);
`endif
         if (k == 1) begin req[3] = 1'b1; setd(3, 2); end
         if (k == 4) req[1] = 1'b0;
         if (m_dn == 3) req[3] = 1'b0;
      end

      // Round-robin, all four requesting with D=3
      rst = 1'b1;
      req = '0;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin setd(i, 3); rr_cd[i] = 0; end
      req = '1;
      pg  = '0;
      for (int k = 1; k <= 28; k++) begin
         cyc();
         if (gnt != '0 && pg == '0) begin
            gq.push_back(oh_idx(gnt));
            gt.push_back(k);
         end
         pg = gnt;
         for (int i = 0; i < NREQ; i++) begin
            if (m_dn == i) begin
               req[i] = 1'b0;
               rr_cd[i] = 2;
            end else if (rr_cd[i] > 0) begin
               rr_cd[i]--;
               if (rr_cd[i] == 0) req[i] = 1'b1;
            end
         end
      end
      chk("rr_grant_count", (gq.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < gq.size()) chk("rr_order", gq[i], i % NREQ);
         if (i + 1 < gt.size() && i < 4) chk("rr_spacing", gt[i+1] - gt[i], 32'd5);
      end

      // Reset in the middle of a run
      rst = 1'b1;
      req = '0;
      cyc();
      rst = 1'b0;
      setd(1, 9);
      req = 4'b0010;
      for (int k = 1; k <= 3; k++) cyc();
      chk("midrst_pre_remain", remain, 32'd7);
      rst = 1'b1;
      req = 4'b1001;
      setd(0, 2);
      setd(3, 2);
      cyc();
      chk("midrst_gnt", gnt, 32'd0);
      chk("midrst_done", done, 32'd0);
      chk("midrst_busy", busy, 32'd0);
      chk("midrst_remain", remain, 32'd0);
      rst = 1'b0;
      cyc();
      chk("midrst_first_gnt", gnt, 32'h1);

      // Randomized requesters
      for (int i = 0; i < NREQ; i++) gap[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NREQ; i++) begin
            dly[i*CB +: CB] = CB'($urandom_range(0, 15));
            if (req[i]) begin
               if (m_dn == i) begin
                  if ($urandom_range(0, 3) != 0) begin
                     req[i] = 1'b0;
                     gap[i] = int'($urandom_range(0, 4));
                  end
               end else if (m_own == i && $urandom_range(0, 39) == 0) begin
                  req[i] = 1'b0;
                  gap[i] = int'($urandom_range(0, 4));
               end
            end else if (gap[i] > 0) begin
               gap[i]--;
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
            end
         end
      end
      rst = 1'b0;
      cyc();
      cmp_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aux_timer_arbiter.md
# aux_timer_arbiter

Shared one-shot delay timer arbitrated among several requesters. Each requester asks for a delay of N clock cycles. The block grants the single down-counter round-robin, times the delay, and returns a one-cycle completion pulse. It sits beside the auxiliary clock dividers in the aux utility layer and replaces per-client private delay counters.

## Interface
- `NumReq`, 4, number of requesters (2..8)
- `CntBit`, 24, delay counter width in bits
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NumReq  level request per requester
- `dly`  in  NumReq*CntBit  flat delay bus; requester i uses `[i*CntBit +: CntBit]`; unsigned cycles
- `gnt`  out  NumReq  one-hot grant, high while the owner's delay runs
- `done`  out  NumReq  one-cycle completion pulse to the owner
- `busy`  out  1  high in RUN or DONE
- `remain`  out  CntBit  current counter value; 0 when idle

## Operation
- FSM states:
  - IDLE: counter free.
  - RUN: counting down for one owner.
  - DONE: one-cycle completion slot.
- IDLE:
  - If any `req` is high, pick the owner round-robin: search starts at index `last+1` and wraps modulo NumReq.
  - Load `remain <= (dly_owner == 0) ? 1 : dly_owner`, set `gnt[owner]`, go to RUN.
  - If no `req`, stay in IDLE.
- RUN:
  - Each cycle, `remain <= remain - 1`.
  - When `remain == 1`: clear `gnt`, pulse `done[owner]`, set `remain <= 0`, go to DONE.
- DONE: update `last <= owner`, go to IDLE. `done` deasserts.
- `dly` is sampled only in the grant cycle. Later changes do not affect the running delay.
- Requester protocol:
  - Hold `req` high until `done`.
  - Drop `req` in the cycle after `done`.
  - A requester still holding `req` in IDLE is treated as a new request and is rescheduled behind the others.
- In RUN, `req` changes from non-owners are ignored. Those requesters simply wait.
- Without abort support, the owner dropping `req` mid-RUN is ignored. The delay completes and `done` still pulses.
- Reset mid-operation returns to IDLE within one cycle. The pending delay is lost and no `done` is issued.
- Reset values: state IDLE, `gnt`=0, `done`=0, `busy`=0, `remain`=0, `last`=NumReq-1, so requester 0 wins first.

## Timing
- `req` sampled high at edge T → `gnt`/`busy` high from T+1, with `remain`=D.
- `gnt` stays high for D cycles (T+1..T+D).
- `done` pulses at T+D+1, in the DONE state.
- IDLE at T+D+2. The earliest next grant is at T+D+3.
- Back-to-back service period is D+2 cycles.
- D=0 behaves as D=1: `gnt` high 1 cycle, `done` at T+2.
- Maximum delay is 2^CntBit−1 cycles. There is no wrap, because the counter never decrements from 0.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Configuration
- `AUX_TIMER_ABORT_EN` defined:
  - In RUN, the owner's `req` sampled low causes the next cycle to be IDLE, with `gnt`=0, `remain`=0 and no `done` pulse.
  - `last` is updated to the owner.
  - If the drop coincides with `remain == 1`, abort wins and no `done` is issued.
- `AUX_TIMER_ABORT_EN` undefined: the owner's `req` is ignored in RUN, as described in Operation.

## Structure
- Shared package `aux_pkg` holds:
  - the state type (IDLE/RUN/DONE) as a 2-bit encoding;
  - the `log2ceil` function used for the owner index width.
- Sub-module `aux_rr_pick`:
  - Combinational round-robin selector. Inputs: `req` vector and `last` index. Outputs: `valid`, one-hot `sel`, binary `idx`.
  - Keeps the FSM and counter free of priority logic.
- Owner index is stored in binary (log2ceil(NumReq) bits). `gnt` and `done` are decoded from it into registers.

## Test plan
- Single request: `req[2]`=1, `dly[2]`=5 at T → `gnt`=4'b0100 for T+1..T+5; `done[2]` at T+6 only; `busy` low from T+7.
- Zero delay: `req[0]`, `dly[0]`=0 → `gnt[0]` for exactly 1 cycle; `done[0]` 2 cycles after sampling.
- Round-robin: after reset, all four requesters hold `req`, each with `dly`=3 → grant order 0,1,2,3,0. Each requester drops `req` after its `done` and re-raises 2 cycles later. Grant spacing is 5 cycles.
- Abort, macro defined: `req[1]`, `dly`=10, `req[1]` dropped at the 4th RUN cycle → `gnt`=0 the next cycle, no `done`, and `req[3]` pending is granted 2 cycles later. With the macro undefined, `done[1]` still appears at T+11.
- Reset mid-RUN: `rst` asserted during RUN with `remain`=7 → next cycle all outputs 0. After release, requester 0 wins over a simultaneous `req[3]`.
- Max delay with `CntBit`=4: `dly`=15 → `gnt` 15 cycles, `remain` sequence 15..1, then 0 at `done`.
